fifo_write_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single write port of one FIFO among NUM_REQ requesters
//  (e.g. UART RX path, debug/command engine, memory dump engine).

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/fifo_write_arbiter_rr_pick.sv | 33 +++
 rtl/fifo_write_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter and its picker.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Index/counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin picker: first valid requester after last_idx, wrapping modulo NUM_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDW-1:0]     last_idx,
  output logic               found,
  output logic [IDW-1:0]     next_idx
);

  int unsigned    idx;
  logic [IDW-1:0] cand;

  // Lowest offset from last_idx wins; offset NUM_REQ re-picks last_idx itself.
  always_comb begin
    found    = 1'b0;
    next_idx = last_idx;
    idx      = 0;
    cand     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx  = (32'(last_idx) + k) % NUM_REQ;
      cand = IDW'(idx);
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        next_idx = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-atomic round-robin arbiter for a single FIFO write port.
// Define FIFO_ARB_TIMEOUT_EN to add the mid-packet idle timeout and timeout_err.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 16
`ifdef FIFO_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT   = 255
`endif
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_last,
  input  logic [NUM_REQ*WIDTH-1:0]           req_data,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               fifo_write,
  output logic [WIDTH-1:0]                   fifo_write_data,
  input  logic                               fifo_full,
  output logic [clog2_min1(NUM_REQ)-1:0]     grant_id,
  output logic                               busy
`ifdef FIFO_ARB_TIMEOUT_EN
  ,
  output logic                               timeout_err
`endif
);

  localparam int unsigned IDW = clog2_min1(NUM_REQ);
  localparam int unsigned BCW = clog2_min1(MAX_BURST + 1);
`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int unsigned ICW = clog2_min1(TIMEOUT + 1);
  logic [ICW-1:0] idle_cnt;
`endif

  arb_state_e     state;
  logic [BCW-1:0] burst_cnt;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic           locked;
  logic           grant_valid;
  logic           grant_last;
  logic           xfer;
  logic           burst_end;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req_valid (req_valid),
    .last_idx  (grant_id),
    .found     (pick_found),
    .next_idx  (pick_idx)
  );

  // Reset gates the port immediately so a mid-packet reset never writes.
  assign locked      = (state == ARB_LOCKED) && rst_n;
  assign grant_valid = req_valid[grant_id];
  assign grant_last  = req_last[grant_id];
  assign xfer        = locked && grant_valid && !fifo_full;
  assign burst_end   = (burst_cnt == BCW'(MAX_BURST - 1));

  assign req_ready       = (locked && !fifo_full) ? (NUM_REQ'(1) << grant_id) : '0;
  assign fifo_write      = xfer;
  assign fifo_write_data = req_data[32'(grant_id)*WIDTH +: WIDTH];
  assign busy            = locked;

  // Grant FSM; grant_id holds after release so the next scan starts past it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      grant_id  <= IDW'(NUM_REQ - 1);
      burst_cnt <= '0;
`ifdef FIFO_ARB_TIMEOUT_EN
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
`ifdef FIFO_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            grant_id  <= pick_idx;
            burst_cnt <= '0;
`ifdef FIFO_ARB_TIMEOUT_EN
            idle_cnt  <= '0;
`endif
            state     <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          if (xfer) begin
            burst_cnt <= burst_cnt + BCW'(1);
`ifdef FIFO_ARB_TIMEOUT_EN
            idle_cnt  <= '0;
`endif
            if (grant_last || burst_end) begin
              state <= ARB_IDLE;
            end
          end
`ifdef FIFO_ARB_TIMEOUT_EN
          // Full-FIFO stalls are not the requester's fault and do not count.
          else if (!grant_valid && !fifo_full) begin
            if (idle_cnt == ICW'(TIMEOUT - 1)) begin
              idle_cnt    <= '0;
              timeout_err <= 1'b1;
              state       <= ARB_IDLE;
            end else begin
              idle_cnt <= idle_cnt + ICW'(1);
            end
          end
`endif
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: directed scenarios plus randomized packets.
module tb_fifo_write_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned W     = 8;
  localparam int unsigned MB    = 4;
  localparam int unsigned TO    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned IDW   = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           fifo_write;
  logic [W-1:0]   fifo_write_data;
  logic           fifo_full = 1'b0;
  logic [IDW-1:0] grant_id;
  logic           busy;
`ifdef FIFO_ARB_TIMEOUT_EN
  logic           timeout_err;
`endif

  fifo_write_arbiter #(
    .NUM_REQ   (N),
    .WIDTH     (W),
    .MAX_BURST (MB)
`ifdef FIFO_ARB_TIMEOUT_EN
    ,
    .TIMEOUT   (TO)
`endif
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_last        (req_last),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .fifo_write      (fifo_write),
    .fifo_write_data (fifo_write_data),
    .fifo_full       (fifo_full),
    .grant_id        (grant_id),
    .busy            (busy)
`ifdef FIFO_ARB_TIMEOUT_EN
    ,
    .timeout_err     (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
  endtask

  // Requester side: each requester presents the head of its word queue ({last,data}).
  typedef logic [W:0] word_t;
  word_t        pend[N][$];
  int           gap[N];
  int           gap_max = 0;
  int           drain_pct = 0;
  logic [N-1:0] accepted = '0;
  logic [W-1:0] fifo_mem[$];
  logic [W-1:0] wlog[$];
  int           wid[$];
  int           stamps[$];
  int           cycle = 0;

  typedef struct {
    int           id;
    logic [W-1:0] data;
  } xfer_t;
  xfer_t exp_q[$];

  // Reference model state: who owns the port and how much of its grant it used.
  bit           m_busy = 0;
  int           m_grant = N - 1;
  int           m_taken = 0;
  int           m_idle = 0;
  bit           m_found;
  bit           m_to_next = 0;
  logic         exp_busy = 0;
  logic [N-1:0] exp_ready = '0;
  logic         exp_to = 0;

  always @(negedge clk) begin
    exp_to    = m_to_next;
    m_to_next = 0;
    if (!rst_n) begin
      exp_busy  = 0;
      exp_ready = '0;
      m_busy    = 0;
      m_grant   = N - 1;
    end else if (!m_busy) begin
      exp_busy  = 0;
      exp_ready = '0;
      m_found   = 0;
      for (int k = 1; k <= N; k++) begin
        if (!m_found && req_valid[(m_grant + k) % N]) begin
          m_found = 1;
          m_grant = (m_grant + k) % N;
        end
      end
      if (m_found) begin
        m_busy  = 1;
        m_taken = 0;
        m_idle  = 0;
      end
    end else begin
      exp_busy  = 1;
      exp_ready = fifo_full ? '0 : N'(1 << m_grant);
      if (!fifo_full && req_valid[m_grant]) begin
        exp_q.push_back('{m_grant, req_data[m_grant*W +: W]});
        m_taken++;
        m_idle = 0;
        if (req_last[m_grant] || m_taken == MB) m_busy = 0;
      end else if (!fifo_full) begin
        m_idle++;
`ifdef FIFO_ARB_TIMEOUT_EN
        if (m_idle == TO) begin
          m_busy    = 0;
          m_to_next = 1;
        end
`endif
      end
    end
  end

  // Monitor: compares every cycle and pops the scoreboard on each FIFO write.
  initial forever begin
    xfer_t e;
    @(negedge clk);
    #2;
    check("busy", 32'(busy), 32'(exp_busy));
    check("req_ready", 32'(req_ready), 32'(exp_ready));
`ifdef FIFO_ARB_TIMEOUT_EN
    check("timeout_err", 32'(timeout_err), 32'(exp_to));
`endif
    if (fifo_write) begin
      check("write_while_full", 32'(fifo_full), 32'(0));
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got data 0x%0h id %0d expected no write (cycle %0d)",
                 fifo_write_data, grant_id, cycle);
      end else begin
        e = exp_q.pop_front();
        check("write_id", 32'(grant_id), 32'(e.id));
        check("write_data", 32'(fifo_write_data), 32'(e.data));
      end
      fifo_mem.push_back(fifo_write_data);
      wlog.push_back(fifo_write_data);
      wid.push_back(int'(grant_id));
      stamps.push_back(cycle);
    end
    accepted = req_valid & req_ready;
  end

  // One clock of stimulus: retire accepted words, drain the FIFO model, present heads.
  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
    for (int i = 0; i < N; i++) begin
      if (accepted[i]) begin
        void'(pend[i].pop_front());
        gap[i] = $urandom_range(gap_max, 0);
      end
    end
    if (fifo_mem.size() > 0 && $urandom_range(99, 0) < drain_pct) void'(fifo_mem.pop_front());
    fifo_full = (fifo_mem.size() >= DEPTH);
    for (int i = 0; i < N; i++) begin
      if (pend[i].size() > 0 && gap[i] == 0) begin
        req_valid[i]       = 1'b1;
        req_last[i]        = pend[i][0][W];
        req_data[i*W +: W] = pend[i][0][W-1:0];
      end else begin
        req_valid[i]       = 1'b0;
        req_last[i]        = 1'b0;
        req_data[i*W +: W] = '0;
        if (gap[i] > 0) gap[i]--;
      end
    end
  endtask

  function automatic bit all_done();
    bit d = (exp_q.size() == 0) && !m_busy;
    for (int i = 0; i < N; i++) if (pend[i].size() != 0) d = 0;
    return d;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!all_done() && n < budget) begin
      step();
      n++;
    end
    repeat (2) step();
    check(name, 32'(all_done()), 32'(1));
  endtask

  task automatic push_pkt(input int r, input logic [W-1:0] first, input int len);
    for (int k = 0; k < len; k++) pend[r].push_back({(k == len - 1), W'(first + W'(k))});
  endtask

  task automatic clear_logs();
    wlog.delete();
    wid.delete();
    stamps.delete();
  endtask

  initial begin
    logic [W-1:0] t1_exp[5];
    logic [W-1:0] t3_exp[7];
    int           n;
    int           pulses;
    t1_exp = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hA1};
    t3_exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h3F, 8'h05, 8'h06};

    repeat (3) step();
    #2;
    check("reset_grant_id", 32'(grant_id), 32'(N - 1));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_fifo_write", 32'(fifo_write), 32'(0));
    rst_n = 1'b1;

    // 1: single-word packets from everyone, writes every other cycle.
    clear_logs();
    push_pkt(0, 8'hA0, 1); push_pkt(0, 8'hA1, 1);
    push_pkt(1, 8'hB0, 1); push_pkt(2, 8'hC0, 1); push_pkt(3, 8'hD0, 1);
    wait_idle("t1_done", 100);
    check("t1_count", 32'(fifo_mem.size()), 32'(5));
    for (int k = 0; k < 5 && k < fifo_mem.size(); k++) check("t1_fifo", 32'(fifo_mem[k]), 32'(t1_exp[k]));
    for (int k = 1; k < stamps.size(); k++) check("t1_spacing", 32'(stamps[k] - stamps[k-1]), 32'(2));
    fifo_mem.delete();

    // 2: multi-word packet stays contiguous against a competing requester.
    drain_pct = 100;
    clear_logs();
    push_pkt(1, 8'h11, 3);
    push_pkt(2, 8'h21, 2);
    wait_idle("t2_done", 100);
    for (int k = 0; k < 3; k++) check("t2_contig", 32'(wlog[k]), 32'(8'h11 + k));
    check("t2_next", 32'(wlog[3]), 32'(8'h21));
    check("t2_next_id", 32'(wid[3]), 32'(2));

    // 3: MAX_BURST release lets req3 in before req0 finishes.
    clear_logs();
    push_pkt(0, 8'h01, 6);
    repeat (2) step();
    push_pkt(3, 8'h3F, 1);
    wait_idle("t3_done", 100);
    check("t3_count", 32'(wlog.size()), 32'(7));
    for (int k = 0; k < 7 && k < wlog.size(); k++) check("t3_order", 32'(wlog[k]), 32'(t3_exp[k]));

    // 4: FIFO full mid-packet stalls without loss or duplication.
    drain_pct = 0;
    fifo_mem.delete();
    clear_logs();
    push_pkt(1, 8'h40, 12);
    repeat (20) step();
    #2;
    check("t4_full", 32'(fifo_full), 32'(1));
    check("t4_no_write", 32'(fifo_write), 32'(0));
    check("t4_no_ready", 32'(req_ready), 32'(0));
    drain_pct = 100;
    wait_idle("t4_done", 200);
    check("t4_count", 32'(wlog.size()), 32'(12));
    for (int k = 0; k < 12 && k < wlog.size(); k++) check("t4_order", 32'(wlog[k]), 32'(8'h40 + k));

    // 5: one-cycle reset mid-packet drops the grant; req0 wins next.
    clear_logs();
    push_pkt(2, 8'h51, 4);
    n = 0;
    while (wlog.size() < 1 && n < 20) begin step(); n++; end
    check("t5_first_write", 32'(wlog.size()), 32'(1));
    rst_n = 1'b0;
    push_pkt(0, 8'h61, 1);
    step();
    rst_n = 1'b1;
    #2;
    check("t5_busy", 32'(busy), 32'(0));
    check("t5_ready", 32'(req_ready), 32'(0));
    wait_idle("t5_done", 100);
    check("t5_regrant_id", 32'(wid[1]), 32'(0));
    check("t5_regrant_data", 32'(wlog[1]), 32'(8'h61));

`ifdef FIFO_ARB_TIMEOUT_EN
    // 6: stalled packet is forcibly released and req3 takes over.
    clear_logs();
    pend[2].push_back({1'b0, 8'h71});
    n = 0;
    while (wlog.size() < 1 && n < 20) begin step(); n++; end
    push_pkt(3, 8'h81, 1);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      #2;
      if (timeout_err) begin
        pulses++;
        check("t6_busy_at_pulse", 32'(busy), 32'(0));
      end
    end
    check("t6_pulses", 32'(pulses), 32'(1));
    pend[2].push_back({1'b0, 8'h72});
    pend[2].push_back({1'b1, 8'h73});
    wait_idle("t6_done", 100);
    check("t6_next_id", 32'(wid[1]), 32'(3));
`else
    pulses = 0;
`endif

    // Randomized packets with gaps and FIFO back-pressure.
    drain_pct = 50;
    gap_max   = 2;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(1, 0) == 1) push_pkt(i, W'($urandom), int'($urandom_range(6, 1)));
      repeat ($urandom_range(8, 0)) step();
    end
    drain_pct = 100;
    wait_idle("random_done", 5000);

    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d passed", passes, checks);
    $fatal(1);
  end

endmodule
